// File: rtl/dsram_arb_dma_if.sv
// dsram_arb_dma_if: core port, DMA config/streams and SRAM macro signals of the data-SRAM controller.
interface dsram_arb_dma_if #(parameter int AW = 14, parameter int LEN_W = 15);
  logic [15:0]      dat_a;
  logic [3:0]       dat_we;
  logic [31:0]      dat_wd;
  logic [3:0]       dat_re;
  logic [31:0]      dat_rd;
  logic             cfg_start;
  logic             cfg_dir;
  logic [AW-1:0]    cfg_addr;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic             done;
  logic             in_vld;
  logic [31:0]      in_data;
  logic             in_rdy;
  logic             out_vld;
  logic [31:0]      out_data;
  logic             out_rdy;
  logic [AW-1:0]    sram_a;
  logic [3:0]       sram_we;
  logic [31:0]      sram_wd;
  logic [3:0]       sram_re;
  logic [31:0]      sram_rd;
  modport slave (
    input  dat_a, dat_we, dat_wd, dat_re, cfg_start, cfg_dir, cfg_addr, cfg_len,
           in_vld, in_data, out_rdy, sram_rd,
    output dat_rd, busy, done, in_rdy, out_vld, out_data, sram_a, sram_we, sram_wd, sram_re
  );
  modport master (
    output dat_a, dat_we, dat_wd, dat_re, cfg_start, cfg_dir, cfg_addr, cfg_len,
           in_vld, in_data, out_rdy, sram_rd,
    input  dat_rd, busy, done, in_rdy, out_vld, out_data, sram_a, sram_we, sram_wd, sram_re
  );
endinterface

// File: rtl/dsram_arb_dma.sv
// dsram_arb_dma: data-SRAM arbiter; the core always wins, a DMA channel streams word blocks in idle cycles.
module dsram_arb_dma #(parameter int AW = 14, parameter int LEN_W = 15) (
  input logic clk,
  input logic rst,
  dsram_arb_dma_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;
  state_t st, st_n;
  logic [AW-1:0] addr, a_q;
  logic [31:0] wd_q;
  logic [LEN_W-1:0] rem, pop_rem;
  logic rd_own, wp, rp, core_act, wr_go, rd_go, pop, start;
  logic [1:0] cnt;
  logic [31:0] fifo [2];
  logic unused;
  assign unused = ^bus.dat_a[1:0];
  assign core_act = |bus.dat_we | |bus.dat_re;
  assign start = st == IDLE && bus.cfg_start;
  assign pop = bus.out_vld & bus.out_rdy;
  assign bus.out_vld = cnt != 2'd0;
  assign bus.out_data = fifo[rp];
  assign bus.dat_rd = bus.sram_rd;
  always_comb begin
    st_n = st;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    bus.in_rdy = 1'b0;
    wr_go = 1'b0;
    rd_go = 1'b0;
    case (st)
      IDLE: if (bus.cfg_start) st_n = bus.cfg_len == '0 ? FIN : bus.cfg_dir ? RD : WR;
      WR: begin
        bus.busy = 1'b1;
        bus.in_rdy = !core_act;
        wr_go = bus.in_vld && !core_act;
        if (wr_go && rem == LEN_W'(1)) st_n = FIN;
      end
      RD: begin
        bus.busy = 1'b1;
        // occupancy plus the read still in flight must leave room in the 2-entry buffer
        rd_go = !core_act && rem != '0 && (cnt + {1'b0, rd_own}) < 2'd2;
        if (pop && pop_rem == LEN_W'(1)) st_n = FIN;
      end
      default: begin
        bus.done = 1'b1;
        st_n = IDLE;
      end
    endcase
  end
  assign bus.sram_a  = core_act ? bus.dat_a[AW+1:2] : (wr_go || rd_go) ? addr : a_q;
  assign bus.sram_wd = core_act ? bus.dat_wd : wr_go ? bus.in_data : wd_q;
  assign bus.sram_we = core_act ? bus.dat_we : {4{wr_go}};
  assign bus.sram_re = core_act ? bus.dat_re : {4{rd_go}};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      addr <= '0;
      a_q <= '0;
      wd_q <= '0;
      rem <= '0;
      pop_rem <= '0;
      rd_own <= 1'b0;
      wp <= 1'b0;
      rp <= 1'b0;
      cnt <= 2'd0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      st <= st_n;
      a_q <= bus.sram_a;
      wd_q <= bus.sram_wd;
      rd_own <= rd_go;
      if (start) begin
        addr <= bus.cfg_addr;
        rem <= bus.cfg_len;
        pop_rem <= bus.cfg_len;
      end else begin
        if (wr_go || rd_go) begin
          addr <= addr + AW'(1);
          rem <= rem - LEN_W'(1);
        end
        if (pop) pop_rem <= pop_rem - LEN_W'(1);
      end
      if (rd_own) begin
        fifo[wp] <= bus.sram_rd;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, rd_own} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_dsram_arb_dma.sv
// tb_dsram_arb_dma: directed checks of the SRAM arbiter/DMA against a behavioural SRAM.
module tb_dsram_arb_dma;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dsram_arb_dma_if #(.AW(14), .LEN_W(15)) bus ();
  dsram_arb_dma #(.AW(14), .LEN_W(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [31:0] mem [0:16383];
  logic [31:0] exp_w [4];
  int n_run = 0;
  int n_fail = 0;
  int n_iss;
  always @(posedge clk) begin
    if (|bus.sram_re) bus.sram_rd <= mem[bus.sram_a];
    for (int b = 0; b < 4; b++)
      if (bus.sram_we[b]) mem[bus.sram_a][8*b +: 8] <= bus.sram_wd[8*b +: 8];
  end
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task tick;
    @(posedge clk);
    #1;
  endtask
  task drain(input string tag, input int n);
    int got;
    bit fin;
    got = 0;
    fin = 1'b0;
    for (int c = 0; c < 50 && !fin; c++) begin
      if (bus.done) fin = 1'b1;
      else if (bus.out_vld) begin
        if (got < n) chk(tag, bus.out_data, exp_w[got]);
        got++;
      end
      if (!fin) begin
        tick;
        #1;
      end
    end
    chk({tag, " count"}, got, n);
    chk({tag, " done"}, 32'(fin), 1);
    chk({tag, " busy at done"}, bus.busy, 0);
  endtask
  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = '0;
    bus.dat_a = '0; bus.dat_we = '0; bus.dat_wd = '0; bus.dat_re = '0;
    bus.cfg_start = 0; bus.cfg_dir = 0; bus.cfg_addr = '0; bus.cfg_len = '0;
    bus.in_vld = 0; bus.in_data = '0; bus.out_rdy = 0; bus.sram_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst in_rdy", bus.in_rdy, 0);
    chk("rst out_vld", bus.out_vld, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst sram_we", bus.sram_we, 0);
    chk("rst sram_re", bus.sram_re, 0);
    @(negedge clk) rst = 0;
    tick;
    // block write of four words
    bus.cfg_start = 1; bus.cfg_dir = 0; bus.cfg_addr = 14'h010; bus.cfg_len = 15'd4;
    bus.in_vld = 1; bus.in_data = 32'hA0;
    #1;
    chk("wr idle in_rdy", bus.in_rdy, 0);
    chk("wr idle we", bus.sram_we, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      bus.cfg_start = 0;
      bus.in_data = 32'hA0 + k;
      #1;
      chk("wr we", bus.sram_we, 4'hF);
      chk("wr addr", bus.sram_a, 32'h10 + k);
      chk("wr data", bus.sram_wd, 32'hA0 + k);
      chk("wr busy", bus.busy, 1);
    end
    tick;
    bus.in_vld = 0;
    #1;
    chk("wr done", bus.done, 1);
    chk("wr busy fin", bus.busy, 0);
    chk("wr fin we", bus.sram_we, 0);
    tick;
    #1;
    chk("wr done low", bus.done, 0);
    chk("wr mem13", mem[14'h13], 32'hA3);
    // block read of the same four words
    bus.cfg_start = 1; bus.cfg_dir = 1; bus.cfg_addr = 14'h010; bus.cfg_len = 15'd4; bus.out_rdy = 1;
    tick;
    bus.cfg_start = 0;
    #1;
    chk("rd issue re", bus.sram_re, 4'hF);
    chk("rd issue addr", bus.sram_a, 32'h10);
    chk("rd vld r0", bus.out_vld, 0);
    tick;
    #1;
    chk("rd vld r1", bus.out_vld, 0);
    tick;
    #1;
    chk("rd vld r2", bus.out_vld, 1);
    exp_w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    drain("rd data", 4);
    tick;
    // core write collides with pending DMA write
    bus.cfg_start = 1; bus.cfg_dir = 0; bus.cfg_addr = 14'h020; bus.cfg_len = 15'd2;
    bus.in_vld = 1; bus.in_data = 32'hB0;
    tick;
    bus.cfg_start = 0;
    bus.dat_we = 4'hF; bus.dat_a = 16'h0040; bus.dat_wd = 32'h0C0DE123;
    #1;
    chk("col in_rdy", bus.in_rdy, 0);
    chk("col core addr", bus.sram_a, 32'h10);
    chk("col core data", bus.sram_wd, 32'h0C0DE123);
    chk("col core we", bus.sram_we, 4'hF);
    tick;
    bus.dat_we = 0;
    #1;
    chk("col retry rdy", bus.in_rdy, 1);
    chk("col dma addr", bus.sram_a, 32'h20);
    chk("col dma data", bus.sram_wd, 32'hB0);
    tick;
    bus.in_data = 32'hB1;
    #1;
    chk("col dma addr2", bus.sram_a, 32'h21);
    tick;
    bus.in_vld = 0;
    #1;
    chk("col done", bus.done, 1);
    tick;
    #1;
    chk("col mem core", mem[14'h10], 32'h0C0DE123);
    chk("col mem b0", mem[14'h20], 32'hB0);
    chk("col mem b1", mem[14'h21], 32'hB1);
    bus.dat_re = 4'hF; bus.dat_a = 16'h0080;
    #1;
    chk("core rd re", bus.sram_re, 4'hF);
    chk("core rd addr", bus.sram_a, 32'h20);
    tick;
    bus.dat_re = 0;
    #1;
    chk("core rd data", bus.dat_rd, 32'hB0);
    // read with consumer stalled for six cycles
    bus.out_rdy = 0;
    bus.cfg_start = 1; bus.cfg_dir = 1; bus.cfg_addr = 14'h010; bus.cfg_len = 15'd4;
    tick;
    bus.cfg_start = 0;
    n_iss = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (bus.sram_re == 4'hF) n_iss++;
      if (c >= 2) chk("stall head", bus.out_data, 32'h0C0DE123);
      tick;
    end
    chk("stall issued", n_iss, 2);
    chk("stall vld", bus.out_vld, 1);
    bus.out_rdy = 1;
    #1;
    exp_w = '{32'h0C0DE123, 32'hA1, 32'hA2, 32'hA3};
    drain("stall data", 4);
    tick;
    // address wrap and zero length
    bus.cfg_start = 1; bus.cfg_dir = 0; bus.cfg_addr = 14'h3FFF; bus.cfg_len = 15'd2;
    bus.in_vld = 1; bus.in_data = 32'hD0;
    tick;
    bus.cfg_start = 0;
    #1;
    chk("wrap addr0", bus.sram_a, 32'h3FFF);
    chk("wrap we0", bus.sram_we, 4'hF);
    tick;
    bus.in_data = 32'hD1;
    #1;
    chk("wrap addr1", bus.sram_a, 32'h0);
    chk("wrap we1", bus.sram_we, 4'hF);
    tick;
    #1;
    chk("wrap done", bus.done, 1);
    tick;
    bus.cfg_start = 1; bus.cfg_dir = 0; bus.cfg_addr = 14'h100; bus.cfg_len = 15'd0;
    #1;
    chk("zero we start", bus.sram_we, 0);
    tick;
    bus.cfg_start = 0;
    #1;
    chk("zero done", bus.done, 1);
    chk("zero busy", bus.busy, 0);
    chk("zero we", bus.sram_we, 0);
    chk("zero re", bus.sram_re, 0);
    tick;
    bus.in_vld = 0;
    #1;
    chk("zero done low", bus.done, 0);
    chk("wrap mem3fff", mem[14'h3FFF], 32'hD0);
    chk("wrap mem0", mem[14'h0], 32'hD1);
    // reset with the read buffer full
    bus.out_rdy = 0;
    bus.cfg_start = 1; bus.cfg_dir = 1; bus.cfg_addr = 14'h020; bus.cfg_len = 15'd4;
    tick;
    bus.cfg_start = 0;
    repeat (3) tick;
    #1;
    chk("rst pre vld", bus.out_vld, 1);
    chk("rst pre busy", bus.busy, 1);
    rst = 1;
    #1;
    chk("rst mid busy", bus.busy, 0);
    chk("rst mid vld", bus.out_vld, 0);
    chk("rst mid done", bus.done, 0);
    @(negedge clk) rst = 0;
    tick;
    bus.cfg_start = 1; bus.cfg_dir = 0; bus.cfg_addr = 14'h030; bus.cfg_len = 15'd1;
    bus.in_vld = 1; bus.in_data = 32'hE0;
    tick;
    bus.cfg_start = 0;
    #1;
    chk("post rst addr", bus.sram_a, 32'h30);
    chk("post rst we", bus.sram_we, 4'hF);
    tick;
    bus.in_vld = 0;
    #1;
    chk("post rst done", bus.done, 1);
    tick;
    #1;
    chk("post rst mem", mem[14'h30], 32'hE0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
